// File: rtl/dispatch_request_queue_pkg.sv
// Shared types and error codes for the scheduler-to-execution dispatch queue.
// The request layout mirrors the 103-bit dispatch word sent by warp_schedular.
package dispatch_request_queue_pkg;

    typedef struct packed {
        logic [4:0]  warp_id;
        logic [62:0] instr;
        logic [31:0] pred;
        logic        alu;
        logic        lsu;
        logic        special;
    } dispatch_req_t;

    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_LSU     = 2'd1,
        CLS_SPECIAL = 2'd2
    } dispatch_class_e;

    // One FIFO slot: full request word plus its decoded class (105 bits).
    typedef struct packed {
        dispatch_req_t   req;
        dispatch_class_e cls;
    } fifo_entry_t;

    localparam logic [31:0] KIANA_SP_ERR_NONE                    = 32'h0000_0000;
    localparam logic [31:0] KIANA_SP_ERR_DISPATCH_QUEUE_OVERFLOW  = 32'h0000_0D01;
    localparam logic [31:0] KIANA_SP_ERR_DISPATCH_QUEUE_BAD_FLAGS = 32'h0000_0D02;
    localparam logic [31:0] KIANA_SP_ERR_DISPATCH_QUEUE_CREDIT    = 32'h0000_0D03;

    // Only meaningful when exactly one flag is set; the caller checks that.
    function automatic dispatch_class_e decode_class(input logic [2:0] flags);
        dispatch_class_e cls;
        if (flags[2])      cls = CLS_ALU;
        else if (flags[1]) cls = CLS_LSU;
        else               cls = CLS_SPECIAL;
        return cls;
    endfunction

endpackage

// File: rtl/dispatch_request_queue_if.sv
// Dispatch bundle: scheduler request side, credit returns and per-unit outputs.
// The queue uses the slave modport; the scheduler/unit side uses master.
interface dispatch_request_queue_if;
    import dispatch_request_queue_pkg::*;

    logic          s_tvalid;
    logic          s_tready;
    dispatch_req_t s_tdata;

    logic          sched_ready_alu;
    logic          sched_ready_lsu;
    logic          sched_ready_special;

    logic [4:0]    m_warp_id;
    logic [62:0]   m_instr;
    logic [31:0]   m_pred;
    logic          m_tvalid_alu;
    logic          m_tvalid_lsu;
    logic          m_tvalid_special;
    logic          m_tready_alu;
    logic          m_tready_lsu;
    logic          m_tready_special;

    modport master (
        output s_tvalid, s_tdata, m_tready_alu, m_tready_lsu, m_tready_special,
        input  s_tready, sched_ready_alu, sched_ready_lsu, sched_ready_special,
        input  m_warp_id, m_instr, m_pred, m_tvalid_alu, m_tvalid_lsu, m_tvalid_special
    );

    modport slave (
        input  s_tvalid, s_tdata, m_tready_alu, m_tready_lsu, m_tready_special,
        output s_tready, sched_ready_alu, sched_ready_lsu, sched_ready_special,
        output m_warp_id, m_instr, m_pred, m_tvalid_alu, m_tvalid_lsu, m_tvalid_special
    );

endinterface

// File: rtl/dispatch_req_fifo.sv
// In-order request buffer: DEPTH entries of payload plus decoded class.
// Full/empty come from the occupancy count alone, so pointers wrap freely.
module dispatch_req_fifo
    import dispatch_request_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fifo_entry_t            push_data,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // NOTE: storage is deliberately not reset; count gates every read, so stale slots never escape.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so pointers and count all see pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/dispatch_request_queue.sv
// Dispatch receive queue: decodes unit flags, buffers requests in order and
// presents them one at a time to the ALU/LSU/special unit with credit tracking.
module dispatch_request_queue
    import dispatch_request_queue_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dispatch_request_queue_if.slave bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             err
);
    // Class counters cover FIFO plus output register, so they can exceed DEPTH by one.
    localparam int            CW      = $clog2(DEPTH) + 2;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    dispatch_req_t   req;
    logic [2:0]      flags;
    logic            flags_ok;
    dispatch_class_e push_cls;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fifo_entry_t     push_entry;
    fifo_entry_t     fifo_head;
    fifo_entry_t     out_entry;
    logic            out_valid;
    logic            out_ready;
    logic            hs;
    logic [2:0]      inc;
    logic [2:0]      dec;
    logic [2:0]      sched_ready;
    logic [CW-1:0]   cnt      [3];
    logic [CW-1:0]   cnt_next [3];
    logic [31:0]     err_next;
    logic            unused_flags;

    assign req        = bus.s_tdata;
    assign flags      = {req.alu, req.lsu, req.special};
    assign flags_ok   = $onehot(flags);
    assign push_cls   = decode_class(flags);
    assign push       = bus.s_tvalid && flags_ok && !fifo_full;
    assign push_entry = '{req: req, cls: push_cls};
    assign bus.s_tready = !fifo_full;

    dispatch_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        // NOTE: default first so every path assigns out_ready and no latch is inferred.
        out_ready = 1'b0;
        case (out_entry.cls)
            CLS_ALU:     out_ready = bus.m_tready_alu;
            CLS_LSU:     out_ready = bus.m_tready_lsu;
            CLS_SPECIAL: out_ready = bus.m_tready_special;
            default:     out_ready = 1'b0;
        endcase
    end

    assign hs  = out_valid && out_ready;
    // Refill whenever the register is empty or being drained: zero-bubble streaming.
    assign pop = !fifo_empty && (!out_valid || hs);

    always_comb begin
        inc = '0;
        dec = '0;
        if (push) inc[push_cls]      = 1'b1;
        if (hs)   dec[out_entry.cls] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt_next[i] = cnt[i];
            if (inc[i] && !dec[i])      cnt_next[i] = cnt[i] + CW'(1);
            else if (dec[i] && !inc[i]) cnt_next[i] = cnt[i] - CW'(1);
        end
    end

    always_comb begin
        err_next = KIANA_SP_ERR_NONE;
        if (bus.s_tvalid && !flags_ok)       err_next = KIANA_SP_ERR_DISPATCH_QUEUE_BAD_FLAGS;
        else if (bus.s_tvalid && fifo_full)  err_next = KIANA_SP_ERR_DISPATCH_QUEUE_OVERFLOW;
        else if (push && cnt[push_cls] >= MAX_CNT)
                                             err_next = KIANA_SP_ERR_DISPATCH_QUEUE_CREDIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_entry   <= '0;
            cnt         <= '{default: '0};
            sched_ready <= '1;
            err         <= '0;
        end else begin
            if (pop) begin
                out_valid <= 1'b1;
                out_entry <= fifo_head;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
            cnt <= cnt_next;
            for (int i = 0; i < 3; i++) sched_ready[i] <= (cnt_next[i] < MAX_CNT);
            err <= err_next;
        end
    end

    assign bus.m_warp_id           = out_entry.req.warp_id;
    assign bus.m_instr             = out_entry.req.instr;
    assign bus.m_pred              = out_entry.req.pred;
    assign bus.m_tvalid_alu        = out_valid && (out_entry.cls == CLS_ALU);
    assign bus.m_tvalid_lsu        = out_valid && (out_entry.cls == CLS_LSU);
    assign bus.m_tvalid_special    = out_valid && (out_entry.cls == CLS_SPECIAL);
    assign bus.sched_ready_alu     = sched_ready[CLS_ALU];
    assign bus.sched_ready_lsu     = sched_ready[CLS_LSU];
    assign bus.sched_ready_special = sched_ready[CLS_SPECIAL];

    // The raw flag bits are superseded by the stored class once decoded.
    assign unused_flags = &{1'b0, out_entry.req.alu, out_entry.req.lsu, out_entry.req.special};

endmodule

// File: tb/tb_dispatch_request_queue.sv
// Bench for dispatch_request_queue: queue-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dispatch_request_queue;
    import dispatch_request_queue_pkg::*;

    localparam int DEPTH        = 8;
    localparam int MAX_INFLIGHT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  count;
    logic [31:0] err;

    always #5 clk = ~clk;

    dispatch_request_queue_if dq_if ();

    dispatch_request_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (dq_if),
        .count (count),
        .err   (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (queue level) ----------------
    dispatch_req_t mq_req [$];
    int            mq_cls [$];
    bit            m_valid;
    dispatch_req_t m_req;
    int            m_cls;
    int            m_cnt [3];
    logic [31:0]   m_err;
    bit            started = 1'b0;
    int            obs_hs  = 0;

    function automatic int cls_of(input logic [2:0] f);
        if (f == 3'b100) return 0;
        if (f == 3'b010) return 1;
        return 2;
    endfunction

    task automatic model_step();
        bit   rdy [3];
        bit   hs;
        bit   pushed;
        int   sz;
        int   cls;
        int   ones;
        logic [2:0] f;
        if (rst) begin
            mq_req.delete();
            mq_cls.delete();
            m_valid = 1'b0;
            m_cnt   = '{0, 0, 0};
            m_err   = 32'h0;
            started = 1'b1;
            return;
        end
        rdy[0] = dq_if.m_tready_alu;
        rdy[1] = dq_if.m_tready_lsu;
        rdy[2] = dq_if.m_tready_special;
        hs     = m_valid && rdy[m_cls];
        f      = {dq_if.s_tdata.alu, dq_if.s_tdata.lsu, dq_if.s_tdata.special};
        ones   = $countones(f);
        cls    = cls_of(f);
        sz     = mq_req.size();
        pushed = dq_if.s_tvalid && ones == 1 && sz < DEPTH;
        if (dq_if.s_tvalid && ones != 1)       m_err = KIANA_SP_ERR_DISPATCH_QUEUE_BAD_FLAGS;
        else if (dq_if.s_tvalid && sz == DEPTH) m_err = KIANA_SP_ERR_DISPATCH_QUEUE_OVERFLOW;
        else if (pushed && m_cnt[cls] >= MAX_INFLIGHT) m_err = KIANA_SP_ERR_DISPATCH_QUEUE_CREDIT;
        else                                    m_err = 32'h0;
        if (hs)     m_cnt[m_cls]--;
        if (pushed) m_cnt[cls]++;
        if (sz > 0 && (!m_valid || hs)) begin
            m_req   = mq_req.pop_front();
            m_cls   = mq_cls.pop_front();
            m_valid = 1'b1;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        if (pushed) begin
            mq_req.push_back(dq_if.s_tdata);
            mq_cls.push_back(cls);
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (started) begin
            check("cmp_tvalid_alu",     dq_if.m_tvalid_alu,     m_valid && m_cls == 0);
            check("cmp_tvalid_lsu",     dq_if.m_tvalid_lsu,     m_valid && m_cls == 1);
            check("cmp_tvalid_special", dq_if.m_tvalid_special, m_valid && m_cls == 2);
            if (m_valid) begin
                check("cmp_warp_id", dq_if.m_warp_id, m_req.warp_id);
                check("cmp_instr",   dq_if.m_instr,   m_req.instr);
                check("cmp_pred",    dq_if.m_pred,    m_req.pred);
            end
            check("cmp_count",     count,          mq_req.size());
            check("cmp_s_tready",  dq_if.s_tready, mq_req.size() != DEPTH);
            check("cmp_sr_alu",    dq_if.sched_ready_alu,     m_cnt[0] < MAX_INFLIGHT);
            check("cmp_sr_lsu",    dq_if.sched_ready_lsu,     m_cnt[1] < MAX_INFLIGHT);
            check("cmp_sr_special", dq_if.sched_ready_special, m_cnt[2] < MAX_INFLIGHT);
            check("cmp_err",       err,            m_err);
            if ((dq_if.m_tvalid_alu && dq_if.m_tready_alu) ||
                (dq_if.m_tvalid_lsu && dq_if.m_tready_lsu) ||
                (dq_if.m_tvalid_special && dq_if.m_tready_special))
                obs_hs++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [4:0] wid, input logic [31:0] pred,
                        input logic [62:0] instr);
        dq_if.s_tvalid = 1'b1;
        dq_if.s_tdata  = '{warp_id: wid, instr: instr, pred: pred,
                           alu: f[2], lsu: f[1], special: f[0]};
    endtask

    task automatic idle();
        dq_if.s_tvalid = 1'b0;
        dq_if.s_tdata  = '0;
    endtask

    task automatic set_ready(input logic a, input logic l, input logic s);
        dq_if.m_tready_alu     = a;
        dq_if.m_tready_lsu     = l;
        dq_if.m_tready_special = s;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((count != 0 || dq_if.m_tvalid_alu || dq_if.m_tvalid_lsu || dq_if.m_tvalid_special)
               && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drain_in_time"}, n < 200, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;
        rst = 1'b1;
        idle();
        set_ready(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        // Reset state
        check("rst_tvalid_alu",     dq_if.m_tvalid_alu,     1'b0);
        check("rst_tvalid_lsu",     dq_if.m_tvalid_lsu,     1'b0);
        check("rst_tvalid_special", dq_if.m_tvalid_special, 1'b0);
        check("rst_count",    count,          4'd0);
        check("rst_s_tready", dq_if.s_tready, 1'b1);
        check("rst_sched",    {dq_if.sched_ready_alu, dq_if.sched_ready_lsu, dq_if.sched_ready_special}, 3'b111);
        check("rst_err",      err,            32'h0);
        check("rst_warp_id",  dq_if.m_warp_id, 5'd0);
        rst = 1'b0;
        tick();

        // Single ALU request, all units ready
        set_ready(1'b1, 1'b1, 1'b1);
        send(3'b100, 5'd5, 32'hFFFF_0000, 63'h123);
        tick();
        idle();
        check("single_count_after_push", count, 4'd1);
        check("single_no_valid_yet", dq_if.m_tvalid_alu, 1'b0);
        tick();
        check("single_valid_alu", dq_if.m_tvalid_alu, 1'b1);
        check("single_warp_id",   dq_if.m_warp_id,    5'd5);
        check("single_pred",      dq_if.m_pred,       32'hFFFF_0000);
        tick();
        check("single_valid_gone", dq_if.m_tvalid_alu, 1'b0);
        check("single_err",        err,                32'h0);
        check("single_sr_alu",     dq_if.sched_ready_alu, 1'b1);

        // Back-to-back ALU, LSU, SPECIAL
        send(3'b100, 5'd1, 32'h1, 63'h11);
        tick();
        send(3'b010, 5'd2, 32'h2, 63'h22);
        tick();
        check("b2b_alu_valid", {dq_if.m_tvalid_alu, dq_if.m_tvalid_lsu, dq_if.m_tvalid_special}, 3'b100);
        check("b2b_alu_wid",   dq_if.m_warp_id, 5'd1);
        send(3'b001, 5'd3, 32'h3, 63'h33);
        tick();
        idle();
        check("b2b_lsu_valid", {dq_if.m_tvalid_alu, dq_if.m_tvalid_lsu, dq_if.m_tvalid_special}, 3'b010);
        check("b2b_lsu_wid",   dq_if.m_warp_id, 5'd2);
        tick();
        check("b2b_spc_valid", {dq_if.m_tvalid_alu, dq_if.m_tvalid_lsu, dq_if.m_tvalid_special}, 3'b001);
        check("b2b_spc_wid",   dq_if.m_warp_id, 5'd3);
        tick();
        check("b2b_idle", {dq_if.m_tvalid_alu, dq_if.m_tvalid_lsu, dq_if.m_tvalid_special}, 3'b000);

        // Backpressure on LSU: credits, fill, overflow
        set_ready(1'b1, 1'b0, 1'b1);
        for (int p = 1; p <= 10; p++) begin
            send(3'b010, 5'(p), 32'h0000_1000 + p, 63'(p * 77));
            tick();
            if (p == 3) check("bp_sr_lsu_still_up", dq_if.sched_ready_lsu, 1'b1);
            if (p == 4) check("bp_sr_lsu_falls",    dq_if.sched_ready_lsu, 1'b0);
            if (p == 5) check("bp_err_credit",      err, KIANA_SP_ERR_DISPATCH_QUEUE_CREDIT);
            if (p == 9) begin
                check("bp_count_full", count,          4'd8);
                check("bp_not_ready",  dq_if.s_tready, 1'b0);
            end
            if (p == 10) begin
                check("bp_err_overflow", err,                KIANA_SP_ERR_DISPATCH_QUEUE_OVERFLOW);
                check("bp_out_held",     dq_if.m_tvalid_lsu, 1'b1);
                check("bp_out_wid",      dq_if.m_warp_id,    5'd1);
            end
        end
        idle();
        set_ready(1'b1, 1'b1, 1'b1);
        drain("bp");

        // Malformed flags
        send(3'b000, 5'd9, 32'h9, 63'h9);
        tick();
        check("bad0_err",   err,   KIANA_SP_ERR_DISPATCH_QUEUE_BAD_FLAGS);
        check("bad0_count", count, 4'd0);
        send(3'b110, 5'd10, 32'hA, 63'hA);
        tick();
        idle();
        check("bad2_err",   err,   KIANA_SP_ERR_DISPATCH_QUEUE_BAD_FLAGS);
        check("bad2_count", count, 4'd0);
        tick();
        check("bad_no_valid", {dq_if.m_tvalid_alu, dq_if.m_tvalid_lsu, dq_if.m_tvalid_special}, 3'b000);
        check("bad_err_clear", err, 32'h0);

        // Wrap-around: 20 alternating ALU/SPECIAL with a fixed ready pattern
        obs_hs = 0;
        sent   = 0;
        cyc    = 0;
        while (sent < 20 && cyc < 400) begin
            set_ready((cyc % 3) != 0, 1'b1, (cyc % 4) != 1);
            if (dq_if.s_tready) begin
                send((sent % 2 == 0) ? 3'b100 : 3'b001, 5'(sent), 32'hA5A5_0000 + sent,
                     63'(sent * 1234567));
                sent++;
            end else begin
                idle();
            end
            tick();
            cyc++;
        end
        idle();
        set_ready(1'b1, 1'b1, 1'b1);
        drain("wrap");
        check("wrap_sent",      sent,   20);
        check("wrap_delivered", obs_hs, 20);
        check("wrap_count",     count,  4'd0);
        check("wrap_sched",     {dq_if.sched_ready_alu, dq_if.sched_ready_lsu, dq_if.sched_ready_special}, 3'b111);

        // Reset mid-operation with 5 queued and special presented
        set_ready(1'b1, 1'b1, 1'b0);
        for (int p = 1; p <= 6; p++) begin
            send(3'b001, 5'(20 + p), 32'hC0DE_0000 + p, 63'(p));
            tick();
        end
        idle();
        check("mid_count",       count,                  4'd5);
        check("mid_spc_valid",   dq_if.m_tvalid_special, 1'b1);
        check("mid_sr_special",  dq_if.sched_ready_special, 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_valids",  {dq_if.m_tvalid_alu, dq_if.m_tvalid_lsu, dq_if.m_tvalid_special}, 3'b000);
        check("mid_rst_count",   count,          4'd0);
        check("mid_rst_s_tready", dq_if.s_tready, 1'b1);
        check("mid_rst_sched",   {dq_if.sched_ready_alu, dq_if.sched_ready_lsu, dq_if.sched_ready_special}, 3'b111);
        rst = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
